vx_barrier_unit: RTL

- Core-side responder for warp-control barrier requests, the `barrier_t` fields issued by the wctl unit.
- Tracks per-barrier arrival counts and the set of waiting warps, and holds those warps stalled.
- Emits a registered release pulse, with a warp mask, when the last warp arrives.
- The scheduler consumes `stall_wmask` and `rel_*` to gate and resume warps.

---
 rtl/vx_barrier_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vx_barrier_unit.sv
// Barrier responder: per-id arrival counting, warp stall tracking, release pulses.
// Optional VX_GBAR_EN adds a global-barrier request/response path.
module vx_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_WIDTH-1:0]  req_wid,
  input  logic [NB_WIDTH-1:0]  req_id,
  input  logic [NW_WIDTH-1:0]  req_size_m1,
  input  logic                 req_is_noop,
  input  logic                 req_is_global,
  output logic [NUM_WARPS-1:0] stall_wmask,
  output logic                 rel_valid,
  output logic [NB_WIDTH-1:0]  rel_id,
  output logic [NUM_WARPS-1:0] rel_wmask,
  output logic                 err_valid
`ifdef VX_GBAR_EN
  ,
  output logic                 gbar_req_valid,
  output logic [NB_WIDTH-1:0]  gbar_req_id,
  output logic [NW_WIDTH-1:0]  gbar_req_size_m1,
  input  logic                 gbar_req_ready,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]  gbar_rsp_id
`endif
);

  typedef logic [NUM_WARPS-1:0] wmask_t;

  // arr_*: every arrival (noop too); wait_*: only warps actually held
  logic [NW_WIDTH-1:0] cnt_q [NUM_BARRIERS];
  logic [NW_WIDTH-1:0] cnt_d [NUM_BARRIERS];
  logic [NW_WIDTH-1:0] size_q [NUM_BARRIERS];
  logic [NW_WIDTH-1:0] size_d [NUM_BARRIERS];
  wmask_t arr_q [NUM_BARRIERS];
  wmask_t arr_d [NUM_BARRIERS];
  wmask_t wait_q [NUM_BARRIERS];
  wmask_t wait_d [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] svld_q, svld_d;

  wmask_t stall_q, stall_d;
  logic rel_v_q, rel_v_d;
  logic [NB_WIDTH-1:0] rel_id_q, rel_id_d;
  wmask_t rel_m_q, rel_m_d;
  logic err_q, err_d;

  logic acc;
  logic loc_rel;
  logic [NW_WIDTH-1:0] eff_size;
  wmask_t wbit;

`ifdef VX_GBAR_EN
  wmask_t garr_q [NUM_BARRIERS];
  wmask_t garr_d [NUM_BARRIERS];
  wmask_t gwait_q [NUM_BARRIERS];
  wmask_t gwait_d [NUM_BARRIERS];
  logic greq_v_q, greq_v_d;
  logic [NB_WIDTH-1:0] greq_id_q, greq_id_d;
  logic [NW_WIDTH-1:0] greq_sz_q, greq_sz_d;
  logic pend_q, pend_d;
  logic [NB_WIDTH-1:0] pend_id_q, pend_id_d;
  logic gsel_v;
  logic [NB_WIDTH-1:0] gsel_id;

  assign req_ready        = reset & ~greq_v_q;
  assign gbar_req_valid   = greq_v_q;
  assign gbar_req_id      = greq_id_q;
  assign gbar_req_size_m1 = greq_sz_q;
`else
  assign req_ready = reset;
`endif

  assign acc         = req_valid & req_ready;
  assign wbit        = wmask_t'(1) << req_wid;
  assign eff_size    = svld_q[req_id] ? size_q[req_id] : req_size_m1;
  assign stall_wmask = stall_q;
  assign rel_valid   = rel_v_q;
  assign rel_id      = rel_id_q;
  assign rel_wmask   = rel_m_q;
  assign err_valid   = err_q;

  always_comb begin
    cnt_d    = cnt_q;
    size_d   = size_q;
    arr_d    = arr_q;
    wait_d   = wait_q;
    svld_d   = svld_q;
    stall_d  = stall_q;
    rel_v_d  = 1'b0;
    rel_id_d = '0;
    rel_m_d  = '0;
    err_d    = 1'b0;
    loc_rel  = 1'b0;
`ifdef VX_GBAR_EN
    garr_d    = garr_q;
    gwait_d   = gwait_q;
    greq_v_d  = greq_v_q & ~gbar_req_ready;
    greq_id_d = greq_id_q;
    greq_sz_d = greq_sz_q;
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    gsel_v    = pend_q | gbar_rsp_valid;
    gsel_id   = pend_q ? pend_id_q : gbar_rsp_id;
`endif
    if (acc) begin
      if (stall_q[req_wid]) begin
        err_d = 1'b1;
`ifdef VX_GBAR_EN
      end else if (req_is_global) begin
        garr_d[req_id] = garr_q[req_id] | wbit;
        if (!req_is_noop) begin
          gwait_d[req_id] = gwait_q[req_id] | wbit;
          stall_d         = stall_d | wbit;
        end
        greq_v_d  = 1'b1;
        greq_id_d = req_id;
        greq_sz_d = req_size_m1;
`endif
      end else begin
        if (svld_q[req_id] && req_size_m1 != size_q[req_id]) err_d = 1'b1;
        if (cnt_q[req_id] == eff_size) begin
          loc_rel        = 1'b1;
          rel_v_d        = 1'b1;
          rel_id_d       = req_id;
          rel_m_d        = arr_q[req_id] | wbit;
          stall_d        = stall_d & ~wait_q[req_id];
          cnt_d[req_id]  = '0;
          arr_d[req_id]  = '0;
          wait_d[req_id] = '0;
          svld_d[req_id] = 1'b0;
        end else begin
          cnt_d[req_id]  = cnt_q[req_id] + 1'b1;
          size_d[req_id] = eff_size;
          svld_d[req_id] = 1'b1;
          arr_d[req_id]  = arr_q[req_id] | wbit;
          if (!req_is_noop) begin
            wait_d[req_id] = wait_q[req_id] | wbit;
            stall_d        = stall_d | wbit;
          end
        end
      end
    end
`ifdef VX_GBAR_EN
    // A local release owns the rel port; a colliding response waits one slot
    if (gbar_rsp_valid && (loc_rel || pend_q)) begin
      pend_d    = 1'b1;
      pend_id_d = gbar_rsp_id;
    end
    if (gsel_v && !loc_rel) begin
      if (pend_q && !gbar_rsp_valid) pend_d = 1'b0;
      rel_v_d          = 1'b1;
      rel_id_d         = gsel_id;
      rel_m_d          = garr_q[gsel_id];
      stall_d          = stall_d & ~gwait_q[gsel_id];
      garr_d[gsel_id]  = garr_d[gsel_id] & ~garr_q[gsel_id];
      gwait_d[gsel_id] = gwait_d[gsel_id] & ~gwait_q[gsel_id];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '{default: '0};
      size_q   <= '{default: '0};
      arr_q    <= '{default: '0};
      wait_q   <= '{default: '0};
      svld_q   <= '0;
      stall_q  <= '0;
      rel_v_q  <= 1'b0;
      rel_id_q <= '0;
      rel_m_q  <= '0;
      err_q    <= 1'b0;
`ifdef VX_GBAR_EN
      garr_q    <= '{default: '0};
      gwait_q   <= '{default: '0};
      greq_v_q  <= 1'b0;
      greq_id_q <= '0;
      greq_sz_q <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      arr_q    <= arr_d;
      wait_q   <= wait_d;
      svld_q   <= svld_d;
      stall_q  <= stall_d;
      rel_v_q  <= rel_v_d;
      rel_id_q <= rel_id_d;
      rel_m_q  <= rel_m_d;
      err_q    <= err_d;
`ifdef VX_GBAR_EN
      garr_q    <= garr_d;
      gwait_q   <= gwait_d;
      greq_v_q  <= greq_v_d;
      greq_id_q <= greq_id_d;
      greq_sz_q <= greq_sz_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
`endif
    end
  end

endmodule
